vga_scanout: RTL
================

Name: vga_scanout

Overview:
- Framebuffer reader: the display-side consumer of the 3-bit VRAM that the CPU fills with draw instructions.
- Generates 640x480 VGA timing (832x520 total) from the system clock.
- Fetches pixels through the VRAM read-only port B and drives 4-bit R/G/B and the syncs.
- Emits frame-start and vblank status for CPU wait/synchronisation logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 832, pixel clocks per line
- H_SYNC_START, 664, first pixel with HSYNC low
- H_SYNC_END, 703, last pixel with HSYNC low (inclusive)
- V_ACTIVE, 480, visible lines
- V_TOTAL, 520, lines per frame
- V_SYNC_START, 489, first line with VSYNC low
- V_SYNC_END, 490, last line with VSYNC low (inclusive)
- WIN_W, 256, framebuffer width; window centred horizontally, left edge (H_ACTIVE-WIN_W)/2 = 192
- WIN_H, 256, framebuffer height; window centred vertically, top edge (V_ACTIVE-WIN_H)/2 = 112
- ADDR_W, 17, VRAM address width
- PIX_W, 3, VRAM pixel width

Ports:
- CLK  in  1  system/pixel clock
- I_RESET  in  1  synchronous, active-high reset
- I_SW  in  4  border colour select; latched once per frame
- O_VRAM_ADDR  out  ADDR_W  VRAM port B address; registered
- I_VRAM_DATA  in  PIX_W  VRAM port B read data; 1-cycle registered-read latency
- O_HSYNC  out  1  active-low horizontal sync
- O_VSYNC  out  1  active-low vertical sync
- O_VIDEO_R  out  4  red
- O_VIDEO_G  out  4  green
- O_VIDEO_B  out  4  blue
- O_FRAME_START  out  1  one-cycle pulse, aligned with the output pixel (0,0)
- O_VBLANK  out  1  high while the output line is >= V_ACTIVE

Behaviour:
- Interface: single clock CLK; reset I_RESET is synchronous and active-high.
- Counters: h (10b) counts 0..H_TOTAL-1, then wraps to 0. v (10b) increments when h wraps, and wraps to 0 after V_TOTAL-1.
- Reset: h=0 and v=0; all pipeline registers cleared; O_HSYNC=1, O_VSYNC=1, colours 0, O_VRAM_ADDR=0, O_FRAME_START=0, O_VBLANK=0; sw latch=0.
- Reset mid-frame restarts at (0,0) on the next cycle. The first cycle after reset release has counter (0,0).
- Pipeline:
  - S0: counter state (h,v).
  - S1: O_VRAM_ADDR registered from (h,v); the in_active, in_window and sync flags are registered alongside it.
  - S2: VRAM data valid; flags delayed one more stage.
  - S3: output registers load.
- Latency: every output reflects the counter value from exactly 3 cycles earlier. Syncs, colours, vblank and frame_start stay mutually aligned.
- Window test: in_window = v in [112,368) and h in [192,448).
- Address: O_VRAM_ADDR = (v-112)*WIN_W + (h-192) when in_window, else 0. The multiply is a shift by log2(WIN_W); the result is truncated to ADDR_W.
- Colour:
  - Blanked (h>=H_ACTIVE or v>=V_ACTIVE): R=G=B=0.
  - In window: R={4{d[0]}}, B={4{d[1]}}, G={4{d[2]}}, where d is I_VRAM_DATA.
  - Active but outside window: R=G=B=4'd3 ^ sw.
- Syncs: O_HSYNC=0 iff h in [664,703]; O_VSYNC=0 iff v in [489,490]; otherwise 1.
- sw latch: I_SW is captured when the counter is at (0,0). A change mid-frame does not affect colour until the next frame.
- O_FRAME_START: high for exactly one cycle per frame.
- O_VBLANK: high for lines 480..519 of the output stream.
- Boundaries:
  - h=831 -> 0 increments v.
  - h=831, v=519 wraps to (0,0) in one cycle.
  - Window edges h=191/192 and 447/448 switch between border and VRAM pixel on exact columns.

Optional Feature:
- Macro SCANOUT_TESTPAT_EN.
- When defined: adds input I_TESTPAT (1b). While I_TESTPAT=1, window pixels use d = O_VRAM_ADDR[2:0] delayed to S2 instead of I_VRAM_DATA. This gives 8-colour vertical stripes without VRAM contents. The port is still driven.
- When undefined: the port is absent and window pixels always come from I_VRAM_DATA.

Decomposition:
- Shared package vga_pkg: all timing constants above, window origin constants, PIX_W/ADDR_W, and the colour-expand function (3b -> three 4b channels).
- One natural sub-module, vga_timing: the h/v counters, sync/active/window flags and frame_start generation. It is reusable by a future capture block.
- vga_scanout instantiates vga_timing and adds the address, pipeline and colour stages.

Test Plan:
- Reset held 5 cycles, then released -> outputs HSYNC=1, VSYNC=1, RGB=0. First O_FRAME_START pulse appears 3 cycles after release; the next one comes 832*520=432640 cycles later.
- Run one line -> O_HSYNC low for exactly 40 cycles, output columns 664..703; period 832 cycles. O_VSYNC low for exactly 2 lines (1664 cycles).
- VRAM model returns addr[2:0]; I_SW=0 -> output (192,112) is R=0,B=0,G=0 from addr 0. (193,112) is R=F. (191,112) is 3. (448,112) is 3. (0,480) is 0 with O_VBLANK=1.
- Check O_VRAM_ADDR at counter (447,367) = 65535; at (448,367) = 0; at (192,113) = 256.
- Change I_SW to 4'h5 at output line 200 -> border stays 3 until the next frame, then becomes 6.
- Assert I_RESET for 1 cycle at (400,300) -> next counter (0,0); outputs reset values for 3 cycles; sw latch cleared.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants, framebuffer window geometry and pixel helpers.
// Used by vga_timing and vga_scanout (optional feature macro: SCANOUT_TESTPAT_EN).
package vga_pkg;

   localparam logic [9:0] H_ACTIVE     = 10'd640;
   localparam logic [9:0] H_TOTAL      = 10'd832;
   localparam logic [9:0] H_SYNC_START = 10'd664;
   localparam logic [9:0] H_SYNC_END   = 10'd703;
   localparam logic [9:0] V_ACTIVE     = 10'd480;
   localparam logic [9:0] V_TOTAL      = 10'd520;
   localparam logic [9:0] V_SYNC_START = 10'd489;
   localparam logic [9:0] V_SYNC_END   = 10'd490;

   localparam logic [9:0] WIN_W  = 10'd256;
   localparam logic [9:0] WIN_H  = 10'd256;
   localparam logic [9:0] WIN_X0 = (H_ACTIVE - WIN_W) / 10'd2;
   localparam logic [9:0] WIN_Y0 = (V_ACTIVE - WIN_H) / 10'd2;
   localparam int         WIN_SHIFT = $clog2(WIN_W);

   localparam int ADDR_W = 17;
   localparam int PIX_W  = 3;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   // Raster flags, all active-high so a cleared register means "blank, no sync".
   typedef struct packed {
      logic active;
      logic window;
      logic hsync;
      logic vsync;
      logic vblank;
      logic frame_start;
   } vga_flags_t;

   function automatic rgb_t expand_pix(input logic [PIX_W-1:0] d);
      rgb_t c;
      c.r = {4{d[0]}};
      c.b = {4{d[1]}};
      c.g = {4{d[2]}};
      return c;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster h/v counters with sync, active, window and frame-start flags.
// flags is registered one cycle behind (h,v); window_now/frame_now are the same-cycle decodes.
module vga_timing
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] h,
   output logic [9:0] v,
   output logic       window_now,
   output logic       frame_now,
   output vga_flags_t flags
);

   logic       h_last;
   logic       v_last;
   vga_flags_t flags_next;

   assign h_last = (h == (H_TOTAL - 10'd1));
   assign v_last = (v == (V_TOTAL - 10'd1));

   // Pixel and line counters; v advances only on the h wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         h <= 10'd0;
         v <= 10'd0;
      end else if (h_last) begin
         h <= 10'd0;
         if (v_last) begin
            v <= 10'd0;
         end else begin
            v <= v + 10'd1;
         end
      end else begin
         h <= h + 10'd1;
      end
   end

   // Decode the current counter position into raster flags.
   always_comb begin
      flags_next             = '0;
      flags_next.active      = (h < H_ACTIVE) && (v < V_ACTIVE);
      flags_next.window      = (h >= WIN_X0) && (h < (WIN_X0 + WIN_W)) &&
                               (v >= WIN_Y0) && (v < (WIN_Y0 + WIN_H));
      flags_next.hsync       = (h >= H_SYNC_START) && (h <= H_SYNC_END);
      flags_next.vsync       = (v >= V_SYNC_START) && (v <= V_SYNC_END);
      flags_next.vblank      = (v >= V_ACTIVE);
      flags_next.frame_start = (h == 10'd0) && (v == 10'd0);
   end

   assign window_now = flags_next.window;
   assign frame_now  = flags_next.frame_start;

   // Flag register, aligned with the registered VRAM address.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= '0;
      end else begin
         flags <= flags_next;
      end
   end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: reads the 256x256 3-bit framebuffer through VRAM port B and drives RGB/syncs.
// Optional macro SCANOUT_TESTPAT_EN adds I_TESTPAT (address-derived colour stripes).
module vga_scanout
   import vga_pkg::*;
(
   input  logic              CLK,
   input  logic              I_RESET,
   input  logic [3:0]        I_SW,
`ifdef SCANOUT_TESTPAT_EN
   input  logic              I_TESTPAT,
`endif
   output logic [ADDR_W-1:0] O_VRAM_ADDR,
   input  logic [PIX_W-1:0]  I_VRAM_DATA,
   output logic              O_HSYNC,
   output logic              O_VSYNC,
   output logic [3:0]        O_VIDEO_R,
   output logic [3:0]        O_VIDEO_G,
   output logic [3:0]        O_VIDEO_B,
   output logic              O_FRAME_START,
   output logic              O_VBLANK
);

   logic [9:0]        h;
   logic [9:0]        v;
   logic              window_now;
   logic              frame_now;
   vga_flags_t        flags_s1;
   vga_flags_t        flags_s2;
   logic [9:0]        h_off;
   logic [9:0]        v_off;
   logic [ADDR_W-1:0] addr_next;
   logic [3:0]        sw_lat;
   logic [3:0]        border;
   logic [PIX_W-1:0]  pix;
   rgb_t              rgb_next;
`ifdef SCANOUT_TESTPAT_EN
   logic [PIX_W-1:0]  tp_s2;
`endif

   vga_timing u_timing (
      .clk        (CLK),
      .reset      (I_RESET),
      .h          (h),
      .v          (v),
      .window_now (window_now),
      .frame_now  (frame_now),
      .flags      (flags_s1)
   );

   // Window-relative address; the row multiply is a shift by log2(WIN_W).
   always_comb begin
      h_off = h - WIN_X0;
      v_off = v - WIN_Y0;
      if (window_now) begin
         addr_next = (ADDR_W'(v_off) << WIN_SHIFT) + ADDR_W'(h_off);
      end else begin
         addr_next = {ADDR_W{1'b0}};
      end
   end

   // S1: registered VRAM address.
   always_ff @(posedge CLK) begin
      if (I_RESET) begin
         O_VRAM_ADDR <= {ADDR_W{1'b0}};
      end else begin
         O_VRAM_ADDR <= addr_next;
      end
   end

   // S2: flags wait for the VRAM read; border select sampled at counter (0,0).
   always_ff @(posedge CLK) begin
      if (I_RESET) begin
         flags_s2 <= '0;
         sw_lat   <= 4'd0;
`ifdef SCANOUT_TESTPAT_EN
         tp_s2    <= {PIX_W{1'b0}};
`endif
      end else begin
         flags_s2 <= flags_s1;
         if (frame_now) begin
            sw_lat <= I_SW;
         end
`ifdef SCANOUT_TESTPAT_EN
         tp_s2    <= O_VRAM_ADDR[PIX_W-1:0];
`endif
      end
   end

   assign border = 4'd3 ^ sw_lat;

   // S3 colour select: blank, framebuffer pixel or border.
   always_comb begin
`ifdef SCANOUT_TESTPAT_EN
      if (I_TESTPAT) begin
         pix = tp_s2;
      end else begin
         pix = I_VRAM_DATA;
      end
`else
      pix = I_VRAM_DATA;
`endif
      if (!flags_s2.active) begin
         rgb_next = '0;
      end else if (flags_s2.window) begin
         rgb_next = expand_pix(pix);
      end else begin
         rgb_next.r = border;
         rgb_next.g = border;
         rgb_next.b = border;
      end
   end

   // S3: output registers; syncs are driven active-low.
   always_ff @(posedge CLK) begin
      if (I_RESET) begin
         O_HSYNC       <= 1'b1;
         O_VSYNC       <= 1'b1;
         O_VIDEO_R     <= 4'd0;
         O_VIDEO_G     <= 4'd0;
         O_VIDEO_B     <= 4'd0;
         O_FRAME_START <= 1'b0;
         O_VBLANK      <= 1'b0;
      end else begin
         O_HSYNC       <= ~flags_s2.hsync;
         O_VSYNC       <= ~flags_s2.vsync;
         O_VIDEO_R     <= rgb_next.r;
         O_VIDEO_G     <= rgb_next.g;
         O_VIDEO_B     <= rgb_next.b;
         O_FRAME_START <= flags_s2.frame_start;
         O_VBLANK      <= flags_s2.vblank;
      end
   end

endmodule
